// File: rtl/led_status_ctrl.sv
// led_status_ctrl
//   Multi-channel board status-LED driver. Each channel is set at run time
//   to off, on, shared heartbeat blink, or activity indicator (pulse-stretched
//   edges of a per-channel activity input, so short bursts stay visible).
//
// Ports:
//   clk     in   1           clock
//   rst     in   1           synchronous, active-high reset
//   i_mode  in   2*NUM_LEDS  per-channel mode, [2i+1:2i]: 00 off, 01 on,
//                            10 heartbeat, 11 activity
//   i_act   in   NUM_LEDS    per-channel activity inputs (may be asynchronous)
//   o_led   out  NUM_LEDS    registered LED drive, inverted when ACTIVE_LOW=1
//   o_hb    out  1           registered raw heartbeat square wave, active-high
module led_status_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 32000000,
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned BLINK_HZ    = 1,
  parameter int unsigned STRETCH_MS  = 50,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NUM_LEDS-1:0] i_mode,
  input  logic [NUM_LEDS-1:0]   i_act,
  output logic [NUM_LEDS-1:0]   o_led,
  output logic                  o_hb
);

  localparam int unsigned HALF_CYCLES    = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int unsigned STRETCH_CYCLES = (CLK_FREQ_HZ / 1000) * STRETCH_MS;
  // Widths hold the full terminal/load value so nothing truncates at the top.
  localparam int unsigned HB_W = (HALF_CYCLES < 1) ? 1 : $clog2(HALF_CYCLES + 1);
  localparam int unsigned ST_W = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HALF_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);
  localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [NUM_LEDS-1:0] POL_MASK = {NUM_LEDS{ACTIVE_LOW}};

  if (HALF_CYCLES < 1) begin : g_bad_half
    $error("led_status_ctrl: HALF_CYCLES must be at least 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("led_status_ctrl: STRETCH_CYCLES must be at least 1");
  end
  if ((NUM_LEDS < 1) || (NUM_LEDS > 32)) begin : g_bad_num
    $error("led_status_ctrl: NUM_LEDS must be in 1..32");
  end

  logic [HB_W-1:0]     hb_cnt_r;
  logic                hb_r;
  logic [NUM_LEDS-1:0] s1_r;
  logic [NUM_LEDS-1:0] s2_r;
  logic [NUM_LEDS-1:0] p_r;
  logic [NUM_LEDS-1:0] edge_s;
  logic [ST_W-1:0]     cnt_r [NUM_LEDS];
  logic [NUM_LEDS-1:0] act_lit_s;
  logic [NUM_LEDS-1:0] sel_s;
  logic [NUM_LEDS-1:0] led_r;

  // Heartbeat: count to HALF_CYCLES-1, then wrap to zero and toggle the wave.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_r <= '0;
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HB_LAST) begin
      hb_cnt_r <= '0;
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HB_ONE;
      hb_r     <= hb_r;
    end
  end

  // Two-flop synchronizer followed by a previous-value flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
      p_r  <= '0;
    end else begin
      s1_r <= i_act;
      s2_r <= s1_r;
      p_r  <= s2_r;
    end
  end

  // Both rising and falling edges of the synchronized input count as activity.
  assign edge_s = s2_r ^ p_r;

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
    // Stretch counter: an edge reloads the full stretch (no accumulation),
    // otherwise count down to zero. Runs regardless of the channel mode.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r[gi] <= '0;
      end else if (edge_s[gi]) begin
        cnt_r[gi] <= ST_LOAD;
      end else if (cnt_r[gi] != '0) begin
        cnt_r[gi] <= cnt_r[gi] - ST_ONE;
      end else begin
        cnt_r[gi] <= cnt_r[gi];
      end
    end

    assign act_lit_s[gi] = (cnt_r[gi] != '0);
  end

  // Per-channel source select from the mode field.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (i_mode[2*i +: 2])
        2'b00:   sel_s[i] = 1'b0;
        2'b01:   sel_s[i] = 1'b1;
        2'b10:   sel_s[i] = hb_r;
        2'b11:   sel_s[i] = act_lit_s[i];
        default: sel_s[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive with polarity applied; reset leaves every LED dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= POL_MASK;
    end else begin
      led_r <= sel_s ^ POL_MASK;
    end
  end

  assign o_led = led_r;
  assign o_hb  = hb_r;

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb_led_status_ctrl
//   Scoreboard bench for led_status_ctrl with HALF_CYCLES=10, STRETCH_CYCLES=6.
//   Two instances share all inputs: one active-high, one active-low.
//   A reference model pushes the expected outputs for every clock edge; a
//   monitor on the falling edge pops and compares.
module tb_led_status_ctrl;

  localparam int N    = 4;
  localparam int HALF = 10;
  localparam int STR  = 6;
  localparam int MAXE = 2048;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2*N-1:0]   i_mode = '0;
  logic [N-1:0]     i_act = '0;
  logic [N-1:0]     o_led;
  logic [N-1:0]     o_led_n;
  logic             o_hb;
  logic             o_hb_n;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .CLK_FREQ_HZ(2000), .NUM_LEDS(N), .BLINK_HZ(100), .STRETCH_MS(3), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_act(i_act), .o_led(o_led), .o_hb(o_hb)
  );

  led_status_ctrl #(
    .CLK_FREQ_HZ(2000), .NUM_LEDS(N), .BLINK_HZ(100), .STRETCH_MS(3), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_act(i_act), .o_led(o_led_n), .o_hb(o_hb_n)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic         hb;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state: edge index, last reset edge, input change history.
  bit         chg [N][MAXE];
  logic [N-1:0] lv = '0;
  int         t = 0;
  int         last_rst = 0;
  logic       prev_hb = 1'b0;

  // A change sampled at edge c is visible after edges c+3 .. c+STR+2,
  // unless a reset edge came at or after c.
  function automatic bit lit(int ch, int tt);
    for (int c = tt - (STR + 2); c <= tt - 3; c++) begin
      if (c > last_rst && c >= 0 && c < MAXE && chg[ch][c]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: expected outputs after each rising edge.
  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk);
      t++;
      e = '0;
      if (rst) begin
        last_rst = t;
        lv = '0;
        for (int ch = 0; ch < N; ch++) if (t < MAXE) chg[ch][t] = 1'b0;
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          if (t < MAXE) chg[ch][t] = (i_act[ch] != lv[ch]);
          lv[ch] = i_act[ch];
        end
        e.hb = ((((t - last_rst) / HALF) % 2) == 1);
        for (int ch = 0; ch < N; ch++) begin
          case (i_mode[2*ch +: 2])
            2'b00:   e.led[ch] = 1'b0;
            2'b01:   e.led[ch] = 1'b1;
            2'b10:   e.led[ch] = prev_hb;
            default: e.led[ch] = lit(ch, t);
          endcase
        end
      end
      prev_hb = e.hb;
      sb_q.push_back(e);
    end
  end

  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0d actual=%b required=%b", name, t, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  initial begin : monitor
    exp_t e2;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty t=%0d actual=none required=entry", t);
      end else begin
        e2 = sb_q.pop_front();
        cmp("o_led", o_led, e2.led);
        cmp("o_led_active_low", o_led_n, ~e2.led);
        cmp("o_hb", {{(N-1){1'b0}}, o_hb}, {{(N-1){1'b0}}, e2.hb});
        cmp("o_hb_active_low", {{(N-1){1'b0}}, o_hb_n}, {{(N-1){1'b0}}, e2.hb});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    // Heartbeat on all channels.
    i_mode = 8'b10_10_10_10;
    step(45);
    // Single activity on ch0, others off.
    i_mode = 8'b00_00_00_11;
    step(4);
    i_act[0] = 1'b1;
    step(12);
    // Retrigger three cycles into the stretch.
    i_act[0] = 1'b0;
    step(3);
    i_act[0] = 1'b1;
    step(15);
    // Static on.
    i_mode = 8'b01_01_01_01;
    step(5);
    // Reset mid-stretch with the heartbeat high.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    i_mode = 8'b00_00_11_10;
    step(12);
    i_act[1] = 1'b1;
    step(2);
    i_act[1] = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(25);
    // Mode switch mid-stretch on ch2.
    i_mode = 8'b00_00_00_00;
    i_act[2] = 1'b1;
    step(5);
    i_mode[5:4] = 2'b11;
    step(12);
    // Randomized traffic, modes and occasional resets.
    repeat (600) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(7) == 0) i_act[ch] = ~i_act[ch];
        if ($urandom_range(19) == 0) i_mode[2*ch +: 2] = 2'($urandom_range(3));
      end
      rst = ($urandom_range(149) == 0);
      step(1);
    end
    rst = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised multi-channel board status-LED driver; replaces ad-hoc per-board heartbeat counters and direct signal-to-LED mirroring in the board top levels.
- Each LED channel is independently set by a runtime mode:
  - off
  - on
  - shared heartbeat blink
  - activity indicator, which pulse-stretches edges on a per-channel activity input (e.g. UART TX) so short bursts stay visible.
- Sits in the board top level between the core/emitter signals and the LED pins.

Parameters:
- CLK_FREQ_HZ, 32000000, frequency of clk in Hz.
- NUM_LEDS, 8, number of LED channels (1..32).
- BLINK_HZ, 1, heartbeat full-period frequency. HALF_CYCLES = CLK_FREQ_HZ/(2*BLINK_HZ).
- STRETCH_MS, 50, activity pulse-stretch duration. STRETCH_CYCLES = (CLK_FREQ_HZ/1000)*STRETCH_MS.
- ACTIVE_LOW, 0, when 1 every o_led bit is inverted (LED on = 0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_mode  in  2*NUM_LEDS  per-channel mode, bits [2i+1:2i] for channel i: 00 off, 01 on, 10 heartbeat, 11 activity. Synchronous to clk.
- i_act  in  NUM_LEDS  per-channel activity inputs; may be asynchronous to clk.
- o_led  out  NUM_LEDS  LED pin drive, registered, polarity per ACTIVE_LOW.
- o_hb  out  1  raw heartbeat square wave, registered, active-high, independent of modes.

Behaviour:
- Elaboration: error if HALF_CYCLES < 1, STRETCH_CYCLES < 1, or NUM_LEDS is outside 1..32.
- Counter widths: $clog2(HALF_CYCLES+1) and $clog2(STRETCH_CYCLES+1); no truncation at max values.
- Reset (rst has priority over every other event in the same cycle):
  - hb_cnt=0, o_hb=0
  - all synchronizer and edge flops=0
  - all stretch counters=0
  - o_led = ACTIVE_LOW ? all ones : all zeros (all LEDs dark).
- Heartbeat:
  - hb_cnt increments every cycle.
  - When hb_cnt==HALF_CYCLES-1: hb_cnt<=0 and o_hb toggles.
  - First o_hb rise is HALF_CYCLES clocks after the first non-reset edge; period is 2*HALF_CYCLES.
  - No off-by-one and no wrap past terminal count.
- Activity path, per channel:
  - i_act goes through a 2-flop synchronizer (s1, s2), then a previous-value flop p.
  - edge = s2 ^ p, so both rising and falling edges count.
  - On edge: cnt <= STRETCH_CYCLES (retrigger restarts the full stretch, no accumulation).
  - Else if cnt != 0: cnt <= cnt-1.
  - act_lit = (cnt != 0).
  - The counter runs in every mode, so switching to mode 11 mid-stretch shows the remaining stretch.
- Output stage: each cycle o_led[i] <= ACTIVE_LOW ^ sel_i, where sel_i is:
  - 0 for mode 00
  - 1 for mode 01
  - the o_hb register value for mode 10
  - act_lit for mode 11
- Latency:
  - i_act toggle (setup before edge 1) -> o_led lit after edge 4.
  - The LED stays lit exactly STRETCH_CYCLES clocks if not retriggered.
  - Mode change -> o_led updates at the next edge.
  - Mode 10 LED lags o_hb by 1 cycle.
- Activity input boundaries:
  - A glitch narrower than one clk may be missed; this is accepted.
  - An i_act pulse of 1+ cycles produces two edges (rise, fall) and so extends the stretch by the pulse width.
  - Constant i_act produces no activity after the first edge.
- rst asserted mid-stretch or mid-heartbeat: all state returns to reset values on that edge; no residual pulse after release.

Test Plan:
All tests use CLK_FREQ_HZ=2000, BLINK_HZ=100, STRETCH_MS=3, NUM_LEDS=4, ACTIVE_LOW=0, so HALF_CYCLES=10 and STRETCH_CYCLES=6.
- Heartbeat: release rst, i_mode=all 10 -> o_hb rises after edge 10, falls after edge 20, period 20. o_led=4'b1111 exactly one cycle after each o_hb rise, 0 one cycle after each fall.
- Single activity: ch0 mode 11, i_act[0] 0->1 before edge 1 -> o_led[0]=1 after edge 4 for exactly 6 cycles, then 0. Other LEDs stay 0 in mode 00.
- Retrigger: toggle i_act[0] again 3 cycles into the stretch -> stretch restarts at 6. Total lit time = 3+6 = 9 cycles, with no gap.
- Static modes and polarity: mode 01 on all channels -> o_led=4'b1111 one cycle after the mode is applied. Repeat with ACTIVE_LOW=1 -> o_led=4'b0000; in reset o_led=4'b1111.
- Reset mid-operation: assert rst while ch1 is lit mid-stretch with o_hb=1 -> after that edge o_led=0 and o_hb=0. After release, ch1 stays dark until a new i_act edge; o_hb first rises 10 cycles after release.
- Mode switch mid-stretch: ch2 edge in mode 00, switch to mode 11 two cycles after the counter loads -> LED lit only for the remaining 4 cycles.
